// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter_if
// Description : Requester, register-file write port and hazard-query bundle
//               for the register-file writeback arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_wb_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_addr;
    logic [31:0] req1_data;
    logic        wr_en;
    logic [3:0]  write_addr;
    logic [31:0] write_data;
    logic [3:0]  chk_addr;
    logic        chk_hit;
    logic        idle;

    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, write_addr, write_data,
        output chk_addr,
        input  chk_hit, idle
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, write_addr, write_data,
        input  chk_addr,
        output chk_hit, idle
    );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter
// Description : Two-requester writeback arbiter for the single register-file
//               write port; per-requester FIFOs, registered output stage and
//               pending-write hazard query. Define REG_WB_RR_ARB_EN for
//               round-robin arbitration (default: requester 1 has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    reg_wb_arbiter_if.slave  bus
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    // Entries are {addr[3:0], data[31:0]}.
    logic [35:0]        mem_q    [2][DEPTH];
    logic [35:0]        mem_d    [2][DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q [2];
    logic [c_ptr_w-1:0] wr_ptr_d [2];
    logic [c_ptr_w-1:0] rd_ptr_q [2];
    logic [c_ptr_w-1:0] rd_ptr_d [2];
    logic [c_cnt_w-1:0] count_q  [2];
    logic [c_cnt_w-1:0] count_d  [2];
    logic               wr_en_q, wr_en_d;
    logic [3:0]         write_addr_q, write_addr_d;
    logic [31:0]        write_data_q, write_data_d;
`ifdef REG_WB_RR_ARB_EN
    logic               rr_q, rr_d;
`endif

    logic [1:0]         w_req_valid;
    logic [1:0]         w_full;
    logic [1:0]         w_nonempty;
    logic [1:0]         w_push;
    logic [1:0]         w_grant;
    logic [35:0]        w_req_entry [2];
    logic [35:0]        w_head      [2];
    logic [c_ptr_w-1:0] w_off;
    logic               w_chk_hit;

    assign w_req_valid    = {bus.req1_valid, bus.req0_valid};
    assign w_req_entry[0] = {bus.req0_addr, bus.req0_data};
    assign w_req_entry[1] = {bus.req1_addr, bus.req1_data};

    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int i = 0; i < 2; i++) begin
            w_full[i]     = (count_q[i] == c_cnt_full);
            w_nonempty[i] = (count_q[i] != '0);
            w_push[i]     = w_req_valid[i] & ~w_full[i];
            w_head[i]     = mem_q[i][rd_ptr_q[i]];
        end
    end

    // A contended grant hands preference to the other requester.
    always_comb begin
        w_grant = w_nonempty;
`ifdef REG_WB_RR_ARB_EN
        rr_d = rr_q;
`endif
        if (&w_nonempty) begin
`ifdef REG_WB_RR_ARB_EN
            w_grant = rr_q ? 2'b10 : 2'b01;
            rr_d    = ~rr_q;
`else
            w_grant = 2'b10;
`endif
        end
    end

    always_comb begin
        mem_d        = mem_q;
        wr_en_d      = |w_grant;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_d[i] = wr_ptr_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            count_d[i]  = count_q[i];
            if (w_push[i]) begin
                mem_d[i][wr_ptr_q[i]] = w_req_entry[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + c_ptr_one;
            end
            if (w_grant[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + c_ptr_one;
            end
            case ({w_push[i], w_grant[i]})
                2'b10:   count_d[i] = count_q[i] + c_cnt_one;
                2'b01:   count_d[i] = count_q[i] - c_cnt_one;
                default: count_d[i] = count_q[i];
            endcase
        end
        if (w_grant[1]) begin
            {write_addr_d, write_data_d} = w_head[1];
        end else if (w_grant[0]) begin
            {write_addr_d, write_data_d} = w_head[0];
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        w_off     = '0;
        w_chk_hit = wr_en_q && (write_addr_q == bus.chk_addr);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_off = c_ptr_w'(j) - rd_ptr_q[i];
                if (({1'b0, w_off} < count_q[i]) && (mem_q[i][j][35:32] == bus.chk_addr)) begin
                    w_chk_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            wr_en_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
`ifdef REG_WB_RR_ARB_EN
            rr_q         <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                count_q[i]  <= count_d[i];
            end
            wr_en_q      <= wr_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
`ifdef REG_WB_RR_ARB_EN
            rr_q         <= rr_d;
`endif
        end
        mem_q <= mem_d;
    end

    assign bus.req0_ready = rst | ~w_full[0];
    assign bus.req1_ready = rst | ~w_full[1];
    assign bus.wr_en      = wr_en_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.chk_hit    = w_chk_hit;
    assign bus.idle       = (count_q[0] == '0) && (count_q[1] == '0) && !wr_en_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_arbiter
// Description : Self-checking bench for reg_wb_arbiter with a queue-based
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_wb_arbiter_if bus();

    reg_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per requester plus the output stage.
    logic [35:0] mq0[$];
    logic [35:0] mq1[$];
    logic        m_wr_en = 1'b0;
    logic [3:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    bit          model_on = 1'b0;
`ifdef REG_WB_RR_ARB_EN
    bit          m_rr = 1'b0;
`endif
    bit          m_acc0, m_acc1;
    int          m_g;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                mq0.delete();
                mq1.delete();
                m_wr_en  = 1'b0;
                m_addr   = '0;
                m_data   = '0;
                model_on = 1'b1;
`ifdef REG_WB_RR_ARB_EN
                m_rr     = 1'b0;
`endif
            end else if (model_on) begin
                m_acc0 = bus.req0_valid && (mq0.size() < DEPTH);
                m_acc1 = bus.req1_valid && (mq1.size() < DEPTH);
                m_g = -1;
                if (mq0.size() > 0 && mq1.size() > 0) begin
`ifdef REG_WB_RR_ARB_EN
                    m_g  = m_rr ? 1 : 0;
                    m_rr = !m_rr;
`else
                    m_g = 1;
`endif
                end else if (mq1.size() > 0) m_g = 1;
                else if (mq0.size() > 0) m_g = 0;
                if (m_g == 1) begin
                    {m_addr, m_data} = mq1.pop_front();
                    m_wr_en = 1'b1;
                end else if (m_g == 0) begin
                    {m_addr, m_data} = mq0.pop_front();
                    m_wr_en = 1'b1;
                end else begin
                    m_wr_en = 1'b0;
                end
                if (m_acc0) mq0.push_back({bus.req0_addr, bus.req0_data});
                if (m_acc1) mq1.push_back({bus.req1_addr, bus.req1_data});
            end
        end
    end

    // Per-cycle compare against the model, plus a write/handshake monitor.
    logic [3:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] dut_rf[16];
    int          wcount = 0;
    int          hs     = 0;
    logic        exp_hit;

    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                exp_hit = m_wr_en && (m_addr == bus.chk_addr);
                foreach (mq0[k]) if (mq0[k][35:32] == bus.chk_addr) exp_hit = 1'b1;
                foreach (mq1[k]) if (mq1[k][35:32] == bus.chk_addr) exp_hit = 1'b1;
                check("cyc_wr_en",      bus.wr_en,      m_wr_en);
                check("cyc_write_addr", bus.write_addr, m_addr);
                check("cyc_write_data", bus.write_data, m_data);
                check("cyc_req0_ready", bus.req0_ready, rst || (mq0.size() < DEPTH));
                check("cyc_req1_ready", bus.req1_ready, rst || (mq1.size() < DEPTH));
                check("cyc_idle",       bus.idle, (mq0.size() == 0) && (mq1.size() == 0) && !m_wr_en);
                check("cyc_chk_hit",    bus.chk_hit,    exp_hit);
            end
            if (bus.wr_en === 1'b1) begin
                log_addr.push_back(bus.write_addr);
                log_data.push_back(bus.write_data);
                dut_rf[bus.write_addr] = bus.write_data;
                wcount++;
            end
            if (rst === 1'b0 && bus.req0_valid && bus.req0_ready === 1'b1) hs++;
            if (rst === 1'b0 && bus.req1_valid && bus.req1_ready === 1'b1) hs++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.idle !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 60), 1'b1);
        next_cycle();
    endtask

    task automatic drive0(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.req0_valid = v;
        bus.req0_addr  = a;
        bus.req0_data  = d;
    endtask

    task automatic drive1(input logic v, input logic [3:0] a, input logic [31:0] d);
        bus.req1_valid = v;
        bus.req1_addr  = a;
        bus.req1_data  = d;
    endtask

    logic        hist[64];
    logic [31:0] exp_seq[12];
    int          n0, n1, k0, k1;
    logic        h0, h1;

    initial begin
        exp_seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6,
                    32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
        drive0(1'b0, 4'd0, 32'd0);
        drive1(1'b0, 4'd0, 32'd0);
        bus.chk_addr = 4'd0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Reset with entries buffered and a write in the output stage.
        drive0(1'b1, 4'd1, 32'h100);
        drive1(1'b1, 4'd2, 32'h200);
        next_cycle();
        drive0(1'b1, 4'd3, 32'h300);
        drive1(1'b1, 4'd4, 32'h400);
        next_cycle();
        drive0(1'b1, 4'd9, 32'h999);
        drive1(1'b0, 4'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_req0_ready", bus.req0_ready, 1'b1);
        check("rst_req1_ready", bus.req1_ready, 1'b1);
        next_cycle();
        rst = 1'b0;
        drive0(1'b0, 4'd0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_wr_en",      bus.wr_en,      1'b0);
            check("post_rst_idle",       bus.idle,       1'b1);
            check("post_rst_write_addr", bus.write_addr, 4'd0);
            check("post_rst_write_data", bus.write_data, 32'd0);
            next_cycle();
        end

        // Single write and its hazard window.
        bus.chk_addr = 4'd3;
        drive0(1'b1, 4'd3, 32'hDEADBEEF);
        @(negedge clk);
        check("single_hit_t0", bus.chk_hit, 1'b0);
        next_cycle();
        drive0(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check("single_wr_en_t1", bus.wr_en,   1'b0);
        check("single_hit_t1",   bus.chk_hit, 1'b1);
        next_cycle();
        @(negedge clk);
        check("single_wr_en_t2", bus.wr_en,      1'b1);
        check("single_addr_t2",  bus.write_addr, 4'd3);
        check("single_data_t2",  bus.write_data, 32'hDEADBEEF);
        check("single_hit_t2",   bus.chk_hit,    1'b1);
        next_cycle();
        @(negedge clk);
        check("single_wr_en_t3", bus.wr_en,   1'b0);
        check("single_hit_t3",   bus.chk_hit, 1'b0);
        next_cycle();

        // Simultaneous writes to the same register.
        bus.chk_addr = 4'd5;
        drive0(1'b1, 4'd5, 32'h11);
        drive1(1'b1, 4'd5, 32'h22);
        next_cycle();
        drive0(1'b0, 4'd0, 32'd0);
        drive1(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check("simul_wr_en_t1", bus.wr_en, 1'b0);
        next_cycle();
        @(negedge clk);
        check("simul_wr_en_t2", bus.wr_en, 1'b1);
`ifdef REG_WB_RR_ARB_EN
        check("simul_data_t2", bus.write_data, 32'h11);
`else
        check("simul_data_t2", bus.write_data, 32'h22);
`endif
        next_cycle();
        @(negedge clk);
        check("simul_wr_en_t3", bus.wr_en, 1'b1);
`ifdef REG_WB_RR_ARB_EN
        check("simul_data_t3", bus.write_data, 32'h22);
`else
        check("simul_data_t3", bus.write_data, 32'h11);
`endif
        next_cycle();
        @(negedge clk);
`ifdef REG_WB_RR_ARB_EN
        check("simul_rf5", dut_rf[5], 32'h22);
`else
        check("simul_rf5", dut_rf[5], 32'h11);
`endif
        next_cycle();

        // Backpressure: req1 streams 1..6, req0 held until A0..A5 all accepted.
        wait_idle("bp_pre_drain");
        log_addr.delete();
        log_data.delete();
        wcount = 0;
        hs     = 0;
        n0 = 0;
        n1 = 0;
        for (int cyc = 1; cyc < 40; cyc++) begin
            drive1(cyc <= 6, 4'd7, 32'(n1 + 1));
            drive0(n0 < 6, 4'd8, 32'hA0 + 32'(n0));
            @(negedge clk);
            hist[cyc] = bus.req0_ready;
            h0 = bus.req0_valid && bus.req0_ready;
            h1 = bus.req1_valid && bus.req1_ready;
            next_cycle();
            if (h0) n0++;
            if (h1) n1++;
            if (cyc >= 6 && n0 >= 6) break;
        end
        drive0(1'b0, 4'd0, 32'd0);
        drive1(1'b0, 4'd0, 32'd0);
        check("bp_req0_all_accepted", n0, 6);
        wait_idle("bp_drain");
        check("bp_writes_eq_handshakes", wcount, hs);
        k0 = 0;
        k1 = 0;
        foreach (log_data[i]) begin
            if (log_addr[i] == 4'd7) begin
                check("bp_req1_order", log_data[i], 32'(k1 + 1));
                k1++;
            end else if (log_addr[i] == 4'd8) begin
                check("bp_req0_order", log_data[i], 32'hA0 + 32'(k0));
                k0++;
            end else begin
                check("bp_unexpected_addr", log_addr[i], 4'd7);
            end
        end
        check("bp_req1_write_count", k1, n1);
        check("bp_req0_write_count", k0, n0);
`ifndef REG_WB_RR_ARB_EN
        check("bp_req1_all_accepted", n1, 6);
        check("bp_log_size", log_data.size(), 12);
        for (int i = 0; i < 12 && i < log_data.size(); i++) begin
            check("bp_sequence", log_data[i], exp_seq[i]);
        end
        check("bp_ready0_c2", hist[2], 1'b1);
        check("bp_ready0_c3", hist[3], 1'b0);
        check("bp_ready0_c7", hist[7], 1'b0);
        check("full_pop_ready0_same_cycle", hist[8], 1'b0);
        check("full_pop_ready0_next_cycle", hist[9], 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Write-port arbiter and sequencer for the 16×32 register file, which has a single write port (`wr_en`/`write_addr`/`write_data`). It accepts writeback requests from two sources: requester 0, the ALU writeback, and requester 1, the load/memory writeback. Each requester gets a 2-deep buffer, and the block drains at most one write per cycle through a registered output stage into the register file. It also reports whether a given register has a write still outstanding, so decode stall logic can detect read-after-write hazards.

## Interface
Parameters:
- `DEPTH`, default 2: entries per requester buffer; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 (ALU) has a write.
- `req0_ready`  out  1  requester 0 buffer not full.
- `req0_addr`  in  4  requester 0 destination register.
- `req0_data`  in  32  requester 0 write data.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_data`: same as requester 0, for requester 1 (load).
- `wr_en`  out  1  drives the register file `wr_en`.
- `write_addr`  out  4  drives the register file `write_addr`.
- `write_data`  out  32  drives the register file `write_data`.
- `chk_addr`  in  4  register being queried for a pending write.
- `chk_hit`  out  1  a write to `chk_addr` is buffered or in the output stage.
- `idle`  out  1  both buffers empty and `wr_en` low.

## Operation
- **Acceptance:** a write is accepted when `reqN_valid && reqN_ready` at a posedge.
  - The entry `{addr, data}` is pushed to buffer N.
  - `reqN_ready` = buffer N not full. It depends only on buffer occupancy, never on `reqN_valid`.
- **Buffers:** each buffer is a FIFO with read/write pointers and a count. Order within one requester is preserved.
- **Arbitration:** combinational, between the two buffer heads.
  - Only one head non-empty: that head is granted.
  - Both heads non-empty: requester 1 wins (fixed priority). See Configuration for the round-robin option.
- **Drain:** the granted head is popped, and the output stage loads `wr_en=1`, `write_addr`, `write_data` on the same edge.
- **No grant:** `wr_en` is loaded with 0, and `write_addr`/`write_data` hold their previous values.
- **Simultaneous push and pop on one buffer:** allowed.
  - The count is unchanged.
  - A full buffer that pops in a cycle still reports `ready=0` that cycle. `ready` is not bypassed.
- **Ordering across requesters:** determined only by grant order. Two writes to the same register from different requesters land in grant order.
- **`chk_hit`:** combinational OR of `addr == chk_addr` over:
  - all valid entries in both buffers, and
  - the output stage when `wr_en=1`.
- **`idle`:** `count0 == 0 && count1 == 0 && !wr_en`.

## Timing
- **Reset:** `rst` high at a posedge sets:
  - both buffers empty (pointers and counts 0);
  - `wr_en=0`, `write_addr=0`, `write_data=0`;
  - round-robin pointer to requester 0 (when compiled in).
- **Reset outputs:** while `rst` is high, `reqN_ready=1` (buffers are empty), but pushes are ignored. Reset overrides the push.
- **Reset mid-operation:** buffered and in-stage writes are discarded, and no `wr_en` pulse follows.
- **Latency:** for a write accepted at the edge ending cycle t, with no contention:
  - it is at the buffer head in cycle t+1;
  - `wr_en=1` in cycle t+2;
  - the register file is updated at the end of cycle t+2.
- **Throughput:** one write per cycle, aggregate across both requesters.
- **`chk_hit` window:** high from cycle t+1 through cycle t+2 inclusive. The register file value is current from cycle t+3.
- **Back-to-back:** sustained single-requester traffic drains one per cycle, so `ready` stays 1.

## Configuration
- **`REG_WB_RR_ARB_EN` defined:** round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - On a contended grant, the pointer moves to the other requester.
  - Uncontended grants leave the pointer unchanged.
  - When both buffers are continuously non-empty, grants alternate 0,1,0,1… starting with requester 0 after reset.
- **Undefined (default):** fixed priority, requester 1 over requester 0. Requester 0 can starve under sustained load traffic.

## Test plan
- **Reset:** assert `rst` with both buffers holding entries, then release.
  - Expect `wr_en` to stay 0 for 3 cycles and `idle=1`.
  - Expect `write_addr=0` and `write_data=0`.
- **Single write:** `req0` writes `{addr=3, data=0xDEADBEEF}` at cycle t.
  - Expect `wr_en=1`, `write_addr=3`, `write_data=0xDEADBEEF` in cycle t+2 only.
  - Expect `chk_addr=3` to give `chk_hit=1` in cycles t+1..t+2 and 0 in cycle t+3.
- **Simultaneous, fixed priority:** `req0 {5, 0x11}` and `req1 {5, 0x22}` in the same cycle.
  - Expect `0x22` written in cycle t+2 and `0x11` in cycle t+3.
  - Register 5 ends at `0x11`.
- **Simultaneous, round-robin:** repeat the previous case with `REG_WB_RR_ARB_EN` defined.
  - The `0x11` write goes first, so register 5 ends at `0x22`.
- **Backpressure:** hold `req1_valid` with consecutive data 1..6 and `req0_valid` with data 0xA0..0xA5 for 6 cycles, no round-robin.
  - Expect `req0_ready` to drop to 0 once its buffer holds 2.
  - Expect all `req1` data written in order with no loss or duplication.
  - Expect `req0` data written afterwards, in order.
- **Full buffer, push and pop:** with buffer 0 full and `req0_valid` held, a pop occurs.
  - Expect `ready` to stay 0 that cycle and become 1 the next.
  - Expect the total writes to equal the accepted handshakes.
